// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit seven-segment bank: drives one shared
// decoder, inserts a blanking gap between digits and swaps the displayed value only per frame.
module seven_seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    lz_en,
  output logic [3:0]              bin_out,
  output logic                    seg_blank,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_start
);

  localparam int unsigned IdxW = $clog2(NUM_DIGITS);
  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam int unsigned ValW = 4 * NUM_DIGITS;

  localparam logic [IdxW-1:0] LastIdx   = IdxW'(NUM_DIGITS - 1);
  localparam logic [CntW-1:0] LastCnt   = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] LastBlank = CntW'(BLANK_CYCLES - 1);

  typedef enum logic [0:0] {StBlank, StDrive} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              run_q;
  logic [ValW-1:0]   active_q, active_d;
  logic [ValW-1:0]   pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic              dark_q, dark_d;
  logic              boundary;

  logic [3:0]            bin_out_d;
  logic                  seg_blank_d;
  logic [NUM_DIGITS-1:0] digit_en_d;
  logic                  frame_start_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StBlank;
      idx_q       <= '0;
      cnt_q       <= '0;
      run_q       <= 1'b0;
      active_q    <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      dark_q      <= 1'b0;
      bin_out     <= '0;
      seg_blank   <= 1'b1;
      digit_en    <= '0;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      run_q       <= 1'b1;
      active_q    <= active_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      dark_q      <= dark_d;
      bin_out     <= bin_out_d;
      seg_blank   <= seg_blank_d;
      digit_en    <= digit_en_d;
      frame_start <= frame_start_d;
    end
  end

  // Registers hold the slot position shown this cycle; run_q low means the next edge
  // is the first frame boundary after reset.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q + 1'b1;
    dark_d     = dark_q;
    boundary   = 1'b0;
    active_d   = active_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;

    if (!run_q) begin
      state_d  = StBlank;
      idx_d    = '0;
      cnt_d    = '0;
      boundary = 1'b1;
    end else if (cnt_q == LastCnt) begin
      cnt_d   = '0;
      state_d = StBlank;
      if (idx_q == LastIdx) begin
        idx_d    = '0;
        boundary = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else if (cnt_q == LastBlank) begin
      // Suppression is decided once at DRIVE entry so lz_en never changes a lit slot.
      state_d = StDrive;
      dark_d  = lz_en && (idx_q != '0) && ((active_q >> (4 * idx_q)) == '0);
    end

    if (boundary) begin
      if (load) begin
        active_d = value_in;
      end else if (pend_vld_q) begin
        active_d = pend_q;
      end
      pend_vld_d = 1'b0;
    end else if (load) begin
      pend_d     = value_in;
      pend_vld_d = 1'b1;
    end
  end

  always_comb begin
    frame_start_d = boundary;
    bin_out_d     = active_d[4*idx_d +: 4];
    digit_en_d    = '0;
    seg_blank_d   = 1'b1;
    if (state_d == StDrive && !dark_d) begin
      digit_en_d[idx_d] = 1'b1;
      seg_blank_d       = 1'b0;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: directed scenarios plus random load/lz_en traffic,
// checked every cycle against a frame-position reference model.
module tb_seven_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FR = ND * RD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        lz_en = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  bin_out;
  logic        seg_blank;
  logic [3:0]  digit_en;
  logic        frame_start;

  int total = 0;
  int bad = 0;

  // Reference model: position within the frame plus the displayed/pending values.
  int          m_pos = 0;
  bit          m_run = 1'b0;
  logic [15:0] m_active = '0;
  logic [15:0] m_pend = '0;
  bit          m_pvld = 1'b0;
  bit          m_dark = 1'b0;
  int          cyc = 0;
  int          last_fs = -1;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value_in   (value_in),
    .lz_en      (lz_en),
    .bin_out    (bin_out),
    .seg_blank  (seg_blank),
    .digit_en   (digit_en),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [3:0] e_bin;
    logic [3:0] e_en;
    logic       e_blank;
    logic       e_fs;
    int         d;
    int         w;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_run    = 1'b0;
      m_active = '0;
      m_pvld   = 1'b0;
      m_dark   = 1'b0;
      last_fs  = -1;
      e_bin    = '0;
      e_en     = '0;
      e_blank  = 1'b1;
      e_fs     = 1'b0;
    end else begin
      if (!m_run) begin
        m_pos = 0;
        m_run = 1'b1;
      end else begin
        m_pos = (m_pos + 1) % FR;
      end
      e_fs = (m_pos == 0);
      if (e_fs) begin
        if (load) m_active = value_in;
        else if (m_pvld) m_active = m_pend;
        m_pvld = 1'b0;
      end else if (load) begin
        m_pend = value_in;
        m_pvld = 1'b1;
      end
      d = m_pos / RD;
      w = m_pos % RD;
      if (w == BC) m_dark = lz_en && (d > 0) && ((m_active >> (4 * d)) == 16'h0);
      e_bin = 4'((m_active >> (4 * d)) & 16'hF);
      if (w >= BC && !m_dark) begin
        e_en    = 4'(1 << d);
        e_blank = 1'b0;
      end else begin
        e_en    = '0;
        e_blank = 1'b1;
      end
    end
    #1;
    chk("bin_out", 32'(bin_out), 32'(e_bin));
    chk("digit_en", 32'(digit_en), 32'(e_en));
    chk("seg_blank", 32'(seg_blank), 32'(e_blank));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("onehot0", 32'($onehot0(digit_en)), 1);
    chk("blank_iff_off", 32'(seg_blank), 32'(digit_en == 4'h0));
    if (frame_start === 1'b1) begin
      if (last_fs >= 0) chk("fs_period", 32'(cyc - last_fs), FR);
      last_fs = cyc;
    end
  endtask

  task automatic run_to(input int p);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 2 * FR && !found; k++) begin
      step();
      if (m_run && m_pos == p) found = 1'b1;
    end
    chk("run_to_reached", 32'(found), 1);
  endtask

  task automatic do_load(input logic [15:0] v);
    load     = 1'b1;
    value_in = v;
    step();
    load     = 1'b0;
  endtask

  initial begin
    // 1: reset values, then slot timing
    repeat (3) step();
    chk("rst_digit_en", 32'(digit_en), 0);
    chk("rst_seg_blank", 32'(seg_blank), 1);
    rst = 1'b0;
    step();
    chk("t1_fs_first", 32'(frame_start), 1);
    chk("t1_blank0", 32'(digit_en), 0);
    run_to(2);  chk("t1_d0_on", 32'(digit_en), 1);
    run_to(7);  chk("t1_d0_last", 32'(digit_en), 1);
    run_to(8);  chk("t1_gap", 32'(digit_en), 0);
    run_to(10); chk("t1_d1_on", 32'(digit_en), 2);

    // 2: load mid-frame, applied at next frame
    run_to(0);
    run_to(5);
    do_load(16'h1234);
    run_to(10); chk("t2_old_bin", 32'(bin_out), 0);
    run_to(2);  chk("t2_d0_bin", 32'(bin_out), 'h4); chk("t2_d0_en", 32'(digit_en), 1);
    run_to(10); chk("t2_d1_bin", 32'(bin_out), 'h3); chk("t2_d1_en", 32'(digit_en), 2);
    run_to(18); chk("t2_d2_bin", 32'(bin_out), 'h2); chk("t2_d2_en", 32'(digit_en), 4);
    run_to(26); chk("t2_d3_bin", 32'(bin_out), 'h1); chk("t2_d3_en", 32'(digit_en), 8);

    // 3: leading-zero suppression
    lz_en = 1'b1;
    do_load(16'h0050);
    run_to(0);
    run_to(4);  chk("t3_d0_bin", 32'(bin_out), 0); chk("t3_d0_en", 32'(digit_en), 1);
    run_to(12); chk("t3_d1_bin", 32'(bin_out), 'h5); chk("t3_d1_en", 32'(digit_en), 2);
    run_to(20); chk("t3_d2_dark", 32'(digit_en), 0); chk("t3_d2_blank", 32'(seg_blank), 1);
    run_to(28); chk("t3_d3_dark", 32'(digit_en), 0);
    do_load(16'h0000);
    run_to(0);
    run_to(4);  chk("t3_zero_d0", 32'(digit_en), 1);
    run_to(12); chk("t3_zero_d1", 32'(digit_en), 0);

    // 4: load on the boundary cycle bypasses pending; last load in a frame wins
    lz_en = 1'b0;
    run_to(31);
    do_load(16'hABCD);
    chk("t4_fs", 32'(frame_start), 1);
    chk("t4_blank_bin", 32'(bin_out), 'hD);
    run_to(2);  chk("t4_d0_bin", 32'(bin_out), 'hD);
    run_to(26); chk("t4_d3_bin", 32'(bin_out), 'hA);
    run_to(5);  do_load(16'h1111);
    run_to(9);  do_load(16'h2222);
    run_to(0);
    run_to(2);  chk("t4_last_d0", 32'(bin_out), 'h2);
    run_to(26); chk("t4_last_d3", 32'(bin_out), 'h2);

    // 5: reset mid-DRIVE discards pending value
    run_to(5);
    do_load(16'h9999);
    run_to(18); chk("t5_d2_en", 32'(digit_en), 4);
    rst = 1'b1;
    step();
    chk("t5_rst_en", 32'(digit_en), 0);
    chk("t5_rst_bin", 32'(bin_out), 0);
    chk("t5_rst_fs", 32'(frame_start), 0);
    rst = 1'b0;
    step();
    chk("t5_fs", 32'(frame_start), 1);
    run_to(26); chk("t5_d3_bin", 32'(bin_out), 0); chk("t5_d3_en", 32'(digit_en), 8);
    run_to(2);  chk("t5_next_bin", 32'(bin_out), 0);

    // 6: random traffic over ten frames
    for (int i = 0; i < 10 * FR; i++) begin
      lz_en    = 1'($urandom_range(0, 1));
      load     = ($urandom_range(0, 7) == 0);
      value_in = 16'($urandom);
      step();
    end
    load = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
